alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU with valid/ready handshakes, a persistent flag register and an optional iterative multiplier. Successor to the 8-bit combinational datapath ALU: generalised width, 4-bit opcode, carry-chained ops (ADC/SBC), and defined shift/overflow semantics. Sits between the register-file read stage and the write-back stage of the CPU datapath.

## Interface
- WIDTH, 8: operand/result width in bits, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount bits taken from b.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept request.
- op  in  4  opcode (see Operation).
- a, b  in  WIDTH  operands.
- flag_en  in  1  this op updates flag register.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- e  out  WIDTH  result.
- flag  out  5  {E,V,C,N,Z}, registered.

## Operation
- Opcodes: 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 NOT a, 5 XOR, 6 SHL a by b[SHW-1:0], 7 SHR (logical), 8 ADC (a+b+C), 9 SBC (a−b−C), 10 CMP (flags of a−b, e=a), 11 MUL (low WIDTH bits of a*b, unsigned), 12–15 illegal.
- Flags computed per op: Z = (e==0); N = e[WIDTH-1]; E = 0 for legal ops.
- ADD/ADC: C = carry out; V = signed overflow. SUB/SBC/CMP: C = borrow (1 when unsigned minuend < subtrahend+borrow-in); V = signed overflow.
- AND/OR/NOT/XOR: C=0, V=0.
- SHL/SHR: shift count is full b value; count ≥ WIDTH → e=0, C=0. Count 0 → e=a, C=0. Otherwise C = last bit shifted out. V=0.
- MUL: C = 1 if upper WIDTH bits of full product nonzero; V=0.
- Illegal op: e=0, flags {E=1,V=0,C=0,N=0,Z=1}.
- Operands, op, flag_en captured at request handshake (in_valid & in_ready).
- flag register written only at result handshake (out_valid & out_ready) when captured flag_en=1; otherwise holds.
- Carry-in for ADC/SBC: the flag C value in effect when the request is accepted; if a result handshake with flag_en=1 completes in the same cycle, the C being written is forwarded.
- FSM: IDLE → (accept non-MUL) DONE; IDLE → (accept MUL) BUSY; BUSY → DONE after WIDTH shift-add iterations; DONE → IDLE on out_ready, or DONE → DONE/BUSY if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from out_ready; no other comb path input→output.
- out_valid = (state==DONE). e and flag-candidate held stable while out_valid & !out_ready.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, e=0, flag=0, multiplier counter=0.
- Non-MUL latency: request accepted cycle N → out_valid in N+1. Back-to-back throughput 1/cycle when out_ready held high.
- MUL latency: accepted cycle N → out_valid in N+WIDTH+1; in_ready=0 throughout BUSY.
- Reset asserted mid-MUL or with out_valid high: result discarded, flag cleared, no handshake completes.
- in_valid while in_ready=0: ignored; requester must hold.

## Configuration
- ALU_MUL_EN defined: opcode 11 implemented as iterative multiplier (BUSY state, counter present).
- ALU_MUL_EN undefined: no BUSY state or multiplier logic; opcode 11 treated as illegal (E=1, e=0, single-cycle latency).

## Test plan
- Reset then WIDTH=8, ADD a=0xFF b=0x01 flag_en=1 → e=0x00 next cycle; after handshake flag={E0,V0,C1,N0,Z1}.
- Back-to-back ADD 0xFF+0x01 then ADC 0x00+0x00, out_ready=1 → second e=0x01 (forwarded C), one result per cycle.
- SUB 0x80−0x01 → e=0x7F, V=1, C=0; CMP 0x01,0x02 → e=0x01, C=1, N=1.
- SHL a=0x81 b=1 → e=0x02, C=1; SHR a=0x81 b=8 → e=0x00, C=0; op=14 → e=0, E=1, Z=1.
- MUL 0x10×0x20 (ALU_MUL_EN) → out_valid exactly 9 cycles after accept, e=0x00, C=1, in_ready low during BUSY; without macro → E=1 after 1 cycle.
- out_ready low 3 cycles with out_valid: e/flag stable, in_ready=0; assert rst mid-MUL → out_valid=0, flag=0, in_ready=1 immediately.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a persistent {E,V,C,N,Z} flag register.
// Define ALU_MUL_EN to build opcode 11 as a WIDTH-iteration shift-add multiplier.
//
// state | meaning
// IDLE  | nothing held, ready for a request
// BUSY  | multiplier iterating, requests refused (ALU_MUL_EN only)
// DONE  | result and flag candidate held until out_ready

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] e,
  output logic [4:0]       flag
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, DONE, BUSY} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  state_t           state, state_nxt, acc_dst;
  logic [4:0]       fcand;
  logic             fen_r;
  logic             acc_req, res_hs, c_in, is_mul, is_sub, big, ci, bi;
  logic [WIDTH:0]   sum, dif, shl, shr;
  logic [WIDTH-1:0] res, zn;
  logic             cf, vf, ef;
  logic [4:0]       fres;
  logic [SHW-1:0]   sh;

  assign acc_req = in_valid & in_ready;
  assign res_hs  = out_valid & out_ready;
  // a flag write landing in the accept cycle supplies the carry-in
  assign c_in    = (res_hs & fen_r) ? fcand[2] : flag[2];

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH+1);
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic               mul_last;

  assign is_mul   = (op == 4'd11);
  assign acc_dst  = is_mul ? BUSY : DONE;
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign mul_last = (state == BUSY) && (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (acc_req && is_mul) begin
      cnt    <= CW'(WIDTH);
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
    end else if (state == BUSY) begin
      cnt    <= cnt - CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= prod_nxt;
    end
  end
`else
  assign is_mul  = 1'b0;
  assign acc_dst = DONE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = acc_dst;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? acc_dst : IDLE;
      end
`ifdef ALU_MUL_EN
      BUSY: if (mul_last) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign ci     = (op == 4'd8) & c_in;
  assign bi     = (op == 4'd9) & c_in;
  assign sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign dif    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
  assign big    = (b >= WLIM);
  assign sh     = b[SHW-1:0];
  assign shl    = {1'b0, a} << sh;
  assign shr    = {a, 1'b0} >> sh;
  assign is_sub = (op == 4'd1) || (op == 4'd9) || (op == 4'd10);
  // CMP reports flags of the difference while passing a through
  assign zn     = is_sub ? dif[WIDTH-1:0] : res;
  assign fres   = {ef, vf, cf, zn[WIDTH-1], ~|zn};

  always_comb begin
    res = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    ef  = 1'b0;
    case (op)
      4'd0, 4'd8: begin
        res = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        vf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1, 4'd9, 4'd10: begin
        res = (op == 4'd10) ? a : dif[WIDTH-1:0];
        cf  = dif[WIDTH];
        vf  = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = ~a;
      4'd5: res = a ^ b;
      4'd6: begin
        res = big ? '0 : shl[WIDTH-1:0];
        cf  = ~big & shl[WIDTH];
      end
      4'd7: begin
        res = big ? '0 : shr[WIDTH:1];
        cf  = ~big & shr[0];
      end
      default: ef = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e     <= '0;
      fcand <= '0;
      fen_r <= 1'b0;
      flag  <= '0;
    end else begin
      if (res_hs && fen_r) flag <= fcand;
      if (acc_req) begin
        fen_r <= flag_en;
        if (!is_mul) begin
          e     <= res;
          fcand <= fres;
        end
      end
`ifdef ALU_MUL_EN
      else if (mul_last) begin
        e     <= prod_nxt[WIDTH-1:0];
        fcand <= {2'b00, |prod_nxt[2*WIDTH-1:WIDTH], prod_nxt[WIDTH-1], ~|prod_nxt[WIDTH-1:0]};
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); expectations come from an integer reference model.
// Multiplier expectations follow ALU_MUL_EN.

module tb_alu_seq;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, flag_en = 1'b0;
  logic [3:0] op = 4'd0;
  logic [7:0] a = 8'd0, b = 8'd0;
  logic       in_ready, out_valid;
  logic [7:0] e;
  logic [4:0] flag;

`ifdef ALU_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .flag_en(flag_en), .out_valid(out_valid), .out_ready(out_ready),
    .e(e), .flag(flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] e;
    logic [4:0] f;
    logic       fen;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  logic sb_c = 1'b0;
  logic [4:0] mdl_flag = 5'd0;
  bit pend = 0, stamped = 0;
  int nerr = 0, nchk = 0, last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [12:0] ref_alu(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                          input logic cin);
    int ux, uy, sx, sy, r, sr, p, bin;
    logic [7:0] res, zn;
    logic c, v, ee;
    ux = int'(x); uy = int'(y); sx = int'($signed(x)); sy = int'($signed(y));
    res = 8'd0; c = 1'b0; v = 1'b0; ee = 1'b0; r = 0; sr = 0; p = 0; bin = 0;
    case (o)
      4'd0, 4'd8: begin
        bin = (o == 4'd8) ? int'(cin) : 0;
        r = ux + uy + bin; sr = sx + sy + bin;
        res = r[7:0]; c = (r > 255); v = (sr > 127) || (sr < -128);
      end
      4'd1, 4'd9, 4'd10: begin
        bin = (o == 4'd9) ? int'(cin) : 0;
        r = ux - uy - bin; sr = sx - sy - bin;
        res = (o == 4'd10) ? x : r[7:0]; c = (r < 0); v = (sr > 127) || (sr < -128);
      end
      4'd2: res = x & y;
      4'd3: res = x | y;
      4'd4: res = ~x;
      4'd5: res = x ^ y;
      4'd6: if (uy >= 8) res = 8'd0;
            else if (uy == 0) res = x;
            else begin res = x << uy; c = x[8-uy]; end
      4'd7: if (uy >= 8) res = 8'd0;
            else if (uy == 0) res = x;
            else begin res = x >> uy; c = x[uy-1]; end
      4'd11: if (MULEN) begin p = ux * uy; res = p[7:0]; c = (p > 255); end
             else ee = 1'b1;
      default: ee = 1'b1;
    endcase
    zn = ((o == 4'd1) || (o == 4'd9) || (o == 4'd10)) ? r[7:0] : res;
    return {ee, v, c, zn[7], (zn == 8'd0), res};
  endfunction

  // call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input logic fe);
    exp_t t;
    logic [12:0] r;
    bit done;
    done = 0;
    in_valid = 1'b1; op = o; a = x; b = y; flag_en = fe;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        r = ref_alu(o, x, y, sb_c);
        t.e = r[7:0]; t.f = r[12:8]; t.fen = fe; t.acc = cyc;
        t.lat = (o == 4'd11 && MULEN) ? 9 : 1;
        sb.push_back(t);
        if (fe) sb_c = r[10];
        last_acc = cyc;
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) out_ready = 1'b1;
    end
    if (!done) check("send_timeout", 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic tp(input string tag, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                    input logic [7:0] ew, input logic [4:0] fw);
    send(o, x, y, 1'b1);
    @(negedge clk); check({tag, "_e"}, 32'(e), 32'(ew));
    @(negedge clk); check({tag, "_flag"}, 32'(flag), 32'(fw));
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_flag"}, 32'(flag), 32'd0);
    check({tag, "_e"}, 32'(e), 32'd0);
    sb.delete();
    sb_c = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t t;
    if (rst) begin
      pend = 0; stamped = 0; mdl_flag = 5'd0;
    end else begin
      if (pend) begin check("flag_reg", 32'(flag), 32'(mdl_flag)); pend = 0; end
      if (out_valid) begin
        check("valid_has_expect", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          if (!stamped) begin check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat)); stamped = 1; end
          if (out_ready) begin
            t = sb.pop_front();
            check("result_e", 32'(e), 32'(t.e));
            if (t.fen) mdl_flag = t.f;
            pend = 1; stamped = 0;
          end
        end
      end
    end
  end

  initial begin
    int acc1;
    repeat (2) @(posedge clk); #1;
    reset_checks("reset");
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    tp("add", 4'd0, 8'hFF, 8'h01, 8'h00, 5'b00101);
    tp("sub", 4'd1, 8'h80, 8'h01, 8'h7F, 5'b01000);

    send(4'd0, 8'hFF, 8'h01, 1'b1);
    acc1 = last_acc;
    send(4'd8, 8'h00, 8'h00, 1'b1);
    check("b2b_spacing", 32'(last_acc - acc1), 32'd1);
    @(negedge clk);
    check("b2b_add_flag", 32'(flag), 32'b00101);
    check("b2b_adc_e", 32'(e), 32'h01);
    @(negedge clk);
    check("b2b_adc_flag", 32'(flag), 32'b00000);
    @(posedge clk); #1;

    tp("cmp", 4'd10, 8'h01, 8'h02, 8'h01, 5'b00110);
    tp("shl", 4'd6, 8'h81, 8'h01, 8'h02, 5'b00100);
    tp("shr", 4'd7, 8'h81, 8'h08, 8'h00, 5'b00001);

    if (MULEN) begin
      send(4'd11, 8'h10, 8'h20, 1'b1);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("mul_busy_in_ready", 32'(in_ready), 32'd0);
        check("mul_busy_out_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk); check("mul_e", 32'(e), 32'h00);
      @(negedge clk); check("mul_flag", 32'(flag), 32'b00101);
      @(posedge clk); #1;
    end else begin
      tp("mul_off", 4'd11, 8'h10, 8'h20, 8'h00, 5'b10001);
    end

    tp("illegal", 4'd14, 8'h12, 8'h34, 8'h00, 5'b10001);

    out_ready = 1'b0;
    send(4'd0, 8'h55, 8'h0A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_e", 32'(e), 32'h5F);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_flag", 32'(flag), 32'b10001);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    out_ready = 1'b0;
    send(4'd5, 8'h3C, 8'h0F, 1'b1);
    @(negedge clk); check("rstv_out_valid_pre", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    reset_checks("rst_valid");
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    if (MULEN) begin
      send(4'd11, 8'hFF, 8'hFF, 1'b1);
      repeat (3) begin @(negedge clk); check("midmul_in_ready", 32'(in_ready), 32'd0); end
      @(posedge clk); #1;
      rst = 1'b1; #1;
      reset_checks("rst_mul");
      @(posedge clk); #1;
      rst = 1'b0;
    end

    for (int i = 0; i < 60; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      send(o, 8'($urandom_range(0, 255)),
           (o == 4'd6 || o == 4'd7) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
